// File: rtl/score_display_ctrl.sv
// Score-to-BCD display controller: double-dabble conversion with a blink overlay.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// state | meaning
// IDLE  | waiting for a score update; upd_ready high
// SHIFT | one double-dabble iteration per cycle, SCORE_W iterations total
// LOAD  | converted digits/blank visible for the first time; done pulse
module score_display_ctrl #(
    parameter int SCORE_W    = 14,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd_valid,
    input  logic [SCORE_W-1:0] upd_score,
    output logic               upd_ready,
    input  logic               blink_en,
    output logic [15:0]        digits,
    output logic [3:0]         blank,
    output logic               done
);

    localparam int ITER_W  = $clog2(SCORE_W + 1);
    localparam int BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BLANK_RST = 4'b1110;
`else
    localparam logic [3:0] BLANK_RST = 4'b0000;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [SCORE_W-1:0] src;
    logic [SCORE_W-1:0] src_clamped;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_next;
    logic [ITER_W-1:0]  iter_cnt;
    logic               accept;
    logic               last_iter;
    logic [3:0]         blank_norm;
    logic [3:0]         blank_conv;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        upd_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (iter_cnt == ITER_W'(1)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = upd_valid && upd_ready;
    assign last_iter = (state == SHIFT) && (iter_cnt == ITER_W'(1));

    // ---------------- conversion datapath ----------------
    // Scores above 9999 cannot be shown on four digits, so they saturate.
    always_comb begin
        src_clamped = upd_score;
        if (32'(upd_score) > 32'd9999) begin
            src_clamped = SCORE_W'(9999);
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = 16'({bcd_adj, src[SCORE_W-1]});
    end

    always_comb begin
        blank_conv = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blank_conv[3] = (bcd_next[15:12] == 4'd0);
        blank_conv[2] = blank_conv[3] && (bcd_next[11:8] == 4'd0);
        blank_conv[1] = blank_conv[2] && (bcd_next[7:4] == 4'd0);
`endif
    end

    // Digits are written on the final iteration edge so they first appear in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            src        <= '0;
            bcd        <= '0;
            iter_cnt   <= '0;
            digits     <= 16'h0000;
            blank_norm <= BLANK_RST;
        end else if (accept) begin
            src      <= src_clamped;
            bcd      <= '0;
            iter_cnt <= ITER_W'(SCORE_W);
        end else if (state == SHIFT) begin
            src      <= {src[SCORE_W-2:0], 1'b0};
            bcd      <= bcd_next;
            iter_cnt <= iter_cnt - ITER_W'(1);
            if (last_iter) begin
                digits     <= bcd_next;
                blank_norm <= blank_conv;
            end
        end
    end

    // ---------------- blink overlay ----------------
    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign blank = (blink_en && blink_phase) ? 4'b1111 : blank_norm;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl (SCORE_W=14, BLINK_HALF=4).
// Expected blank values follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [13:0] upd_score;
    logic        upd_ready;
    logic        blink_en;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] last_digits;
    logic [3:0]  last_blank;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    always #5 clk = ~clk;

    score_display_ctrl #(
        .SCORE_W    (14),
        .BLINK_HALF (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upd_valid (upd_valid),
        .upd_score (upd_score),
        .upd_ready (upd_ready),
        .blink_en  (blink_en),
        .digits    (digits),
        .blank     (blank),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pick(input logic [3:0] en_val);
        return LZB ? en_val : 4'b0000;
    endfunction

    // One accepted conversion with full latency and hold checks.
    task automatic convert(input logic [13:0] score, input logic [15:0] exp_d,
                           input logic [3:0] exp_b_en, input bit chk_blank, input string tag);
        logic [3:0] exp_b;
        exp_b = pick(exp_b_en);
        check({tag, ":ready_idle"}, 32'(upd_ready), 32'd1);
        upd_valid = 1'b1;
        upd_score = score;
        tick();
        upd_valid = 1'b0;
        upd_score = 14'h2AAA;
        for (int c = 1; c <= 14; c++) begin
            check({tag, ":ready_busy"}, 32'(upd_ready), 32'd0);
            check({tag, ":done_early"}, 32'(done), 32'd0);
            check({tag, ":digits_hold"}, 32'(digits), 32'(last_digits));
            if (chk_blank) check({tag, ":blank_hold"}, 32'(blank), 32'(last_blank));
            tick();
        end
        check({tag, ":done_c15"}, 32'(done), 32'd1);
        check({tag, ":digits_c15"}, 32'(digits), 32'(exp_d));
        check({tag, ":ready_c15"}, 32'(upd_ready), 32'd0);
        if (chk_blank) check({tag, ":blank_c15"}, 32'(blank), 32'(exp_b));
        tick();
        check({tag, ":ready_c16"}, 32'(upd_ready), 32'd1);
        check({tag, ":done_c16"}, 32'(done), 32'd0);
        check({tag, ":digits_c16"}, 32'(digits), 32'(exp_d));
        last_digits = exp_d;
        last_blank  = exp_b;
    endtask

    initial begin
        int pulses;
        int p1_c, p2_c;
        logic [15:0] p1_d, p2_d;

        // reset with a competing update request
        reset     = 1'b1;
        upd_valid = 1'b1;
        upd_score = 14'd5;
        blink_en  = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        upd_valid = 1'b0;
        check("rst:digits", 32'(digits), 32'h0000);
        check("rst:done", 32'(done), 32'd0);
        check("rst:ready", 32'(upd_ready), 32'd1);
        check("rst:blank", 32'(blank), 32'(pick(4'b1110)));
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) pulses++;
            tick();
        end
        check("rst:no_done", 32'(pulses), 32'd0);
        check("rst:digits_after", 32'(digits), 32'h0000);
        last_digits = 16'h0000;
        last_blank  = pick(4'b1110);

        convert(14'd0,     16'h0000, 4'b1110, 1'b1, "zero");
        convert(14'd1234,  16'h1234, 4'b0000, 1'b1, "s1234");
        convert(14'h3FFF,  16'h9999, 4'b0000, 1'b1, "clamp_max");
        convert(14'd10000, 16'h9999, 4'b0000, 1'b1, "clamp_10000");
        convert(14'd9999,  16'h9999, 4'b0000, 1'b1, "s9999");
        convert(14'd5,     16'h0005, 4'b1110, 1'b1, "s5");
        convert(14'd100,   16'h0100, 4'b1000, 1'b1, "s100");
        convert(14'd45,    16'h0045, 4'b1100, 1'b1, "s45");

        // blink: 4 cycles normal, 4 cycles all-off, repeating
        blink_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("blink:pattern", 32'(blank), ((k / 4) % 2 == 1) ? 32'hF : 32'(last_blank));
            if (k < 15) tick();
        end
        blink_en = 1'b0;
        tick();
        check("blink:off_next", 32'(blank), 32'(last_blank));
        tick();
        tick();
        blink_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("blink:restart", 32'(blank), (k >= 4) ? 32'hF : 32'(last_blank));
            tick();
        end
        convert(14'd2468, 16'h2468, 4'b0000, 1'b0, "blink_conv");
        blink_en = 1'b0;
        tick();
        check("blink:conv_blank", 32'(blank), 32'(last_blank));

        // update held high during a conversion: queued by the requester, not the DUT
        upd_valid = 1'b1;
        upd_score = 14'd1234;
        tick();
        upd_score = 14'd45;
        pulses = 0;
        p1_c = 0; p2_c = 0;
        p1_d = 16'h0; p2_d = 16'h0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 17) upd_valid = 1'b0;
            if (c == 16) check("b2b:ready_c16", 32'(upd_ready), 32'd1);
            if (done) begin
                pulses++;
                if (pulses == 1) begin p1_c = c; p1_d = digits; end
                if (pulses == 2) begin p2_c = c; p2_d = digits; end
            end
            tick();
        end
        check("b2b:pulses", 32'(pulses), 32'd2);
        check("b2b:p1_cycle", 32'(p1_c), 32'd15);
        check("b2b:p1_digits", 32'(p1_d), 32'h1234);
        check("b2b:p2_cycle", 32'(p2_c), 32'd31);
        check("b2b:p2_digits", 32'(p2_d), 32'h0045);
        last_digits = 16'h0045;
        last_blank  = pick(4'b1100);

        // reset during iteration 7 of 777
        upd_valid = 1'b1;
        upd_score = 14'd777;
        tick();
        upd_valid = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        check("abort:digits_before", 32'(digits), 32'h0045);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort:digits", 32'(digits), 32'h0000);
        check("abort:done", 32'(done), 32'd0);
        check("abort:ready", 32'(upd_ready), 32'd1);
        check("abort:blank", 32'(blank), 32'(pick(4'b1110)));
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) pulses++;
            tick();
        end
        check("abort:no_done", 32'(pulses), 32'd0);
        check("abort:digits_after", 32'(digits), 32'h0000);
        last_digits = 16'h0000;
        last_blank  = pick(4'b1110);
        convert(14'd777, 16'h0777, 4'b1000, 1'b1, "s777");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
